ysyx_23060221_ifu: RTL and testbench

Instruction fetch unit of the multi-cycle NPC core: the producing end of the IFU→IDU valid/ready handshake. It holds the architectural PC, fetches one 32-bit instruction per round through a request/response instruction-memory port, and presents `inst`/`pc` to the decoder. It then waits for the next PC from write-back before fetching again.

---
 rtl/ysyx_23060221_ifu.sv | 138 +++++++++++++
 tb/tb_ysyx_23060221_ifu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060221_ifu.sv
// rtl/ysyx_23060221_ifu.sv - instruction fetch unit, producer side of the IFU->IDU handshake
// One fetch per round: request, wait for response or timeout, hand to IDU, wait for next PC.
module ysyx_23060221_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rsp_err,
  output logic        IFU_valid,
  input  logic        IDU_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        ifu_fault,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        IFU_ready,
  output logic [63:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_NEXT  = 3'd4
  } state_e;

  localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT[7:0];

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        fault_q;
  logic [63:0] fetch_cnt_q;
  logic [7:0]  tmo_cnt_q;
  logic [7:0]  tmo_cnt_d;
  logic        req_valid_q;
  logic        ifu_valid_q;
  logic        ifu_ready_q;
  logic        pc_misaligned;
  logic        tmo_hit;

  assign tmo_cnt_d     = tmo_cnt_q + 8'd1;
  // A zero limit never matches because the counter compare is gated off.
  assign tmo_hit       = (TIMEOUT_LIMIT != 8'd0) && (tmo_cnt_d == TIMEOUT_LIMIT);
  assign pc_misaligned = (pc_q[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= 32'h0;
      fault_q     <= 1'b0;
      fetch_cnt_q <= 64'h0;
      tmo_cnt_q   <= 8'h0;
      req_valid_q <= 1'b0;
      ifu_valid_q <= 1'b0;
      ifu_ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
        end
        // The request flop rises one cycle into REQ, so a misaligned PC
        // is caught before anything reaches the memory port.
        S_REQ: begin
          if (pc_misaligned) begin
            inst_q      <= 32'h0;
            fault_q     <= 1'b1;
            req_valid_q <= 1'b0;
            ifu_valid_q <= 1'b1;
            state_q     <= S_VALID;
          end else if (!req_valid_q) begin
            req_valid_q <= 1'b1;
          end else if (imem_req_ready) begin
            req_valid_q <= 1'b0;
            tmo_cnt_q   <= 8'h0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            inst_q      <= imem_rdata;
            fault_q     <= imem_rsp_err;
            ifu_valid_q <= 1'b1;
            state_q     <= S_VALID;
          end else if (tmo_hit) begin
            inst_q      <= 32'h0;
            fault_q     <= 1'b1;
            tmo_cnt_q   <= tmo_cnt_d;
            ifu_valid_q <= 1'b1;
            state_q     <= S_VALID;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
          end
        end
        S_VALID: begin
          if (IDU_ready) begin
            fetch_cnt_q <= fetch_cnt_q + 64'd1;
            ifu_valid_q <= 1'b0;
            ifu_ready_q <= 1'b1;
            state_q     <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (npc_valid) begin
            pc_q        <= npc;
            fault_q     <= 1'b0;
            ifu_ready_q <= 1'b0;
            state_q     <= S_REQ;
          end
        end
        default: begin
          req_valid_q <= 1'b0;
          ifu_valid_q <= 1'b0;
          ifu_ready_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign IFU_valid      = ifu_valid_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign ifu_fault      = fault_q;
  assign IFU_ready      = ifu_ready_q;
  assign fetch_cnt      = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_23060221_ifu.sv
// tb/tb_ysyx_23060221_ifu.sv - scoreboard bench for the instruction fetch unit
module tb_ysyx_23060221_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        imem_rsp_err;
  logic        IFU_valid;
  logic        IDU_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        ifu_fault;
  logic        npc_valid;
  logic [31:0] npc;
  logic        IFU_ready;
  logic [63:0] fetch_cnt;

  ysyx_23060221_ifu #(
    .RESET_PC(32'h8000_0000),
    .TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rdata    (imem_rdata),
    .imem_rsp_err  (imem_rsp_err),
    .IFU_valid     (IFU_valid),
    .IDU_ready     (IDU_ready),
    .inst          (inst),
    .pc            (pc),
    .ifu_fault     (ifu_fault),
    .npc_valid     (npc_valid),
    .npc           (npc),
    .IFU_ready     (IFU_ready),
    .fetch_cnt     (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          failures;
  int          cyc;
  int          acc_cyc;
  int          rel_cyc;
  int          req_seen;
  int          mem_mode;
  logic [63:0] exp_cnt;
  exp_t        cur;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'h5a5a_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model: always ready, answers one cycle after acceptance unless mode 2.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_addr;
    if (imem_req_valid) req_seen++;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) acc_cyc = cyc;
    imem_rsp_valid = acc && (mem_mode != 2);
    imem_rdata     = acc ? mem_word(a) : 32'h0;
    imem_rsp_err   = acc && (mem_mode == 1);
  endtask

  task automatic push_exp(input logic [31:0] p);
    exp_t e;
    e.pc = p;
    if (p[1:0] != 2'b00 || mem_mode == 2) begin
      e.inst  = 32'h0;
      e.fault = 1'b1;
    end else begin
      e.inst  = mem_word(p);
      e.fault = (mem_mode == 1);
    end
    sb.push_back(e);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!IFU_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid_seen"}, 64'(IFU_valid), 64'd1);
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      cur = sb.pop_front();
      check_eq({tag, "_pc"}, 64'(pc), 64'(cur.pc));
      check_eq({tag, "_inst"}, 64'(inst), 64'(cur.inst));
      check_eq({tag, "_fault"}, 64'(ifu_fault), 64'(cur.fault));
    end
  endtask

  task automatic handoff(input string tag);
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
    exp_cnt++;
    check_eq({tag, "_fetch_cnt"}, fetch_cnt, exp_cnt);
    check_eq({tag, "_ifu_ready"}, 64'(IFU_ready), 64'd1);
    check_eq({tag, "_valid_drop"}, 64'(IFU_valid), 64'd0);
  endtask

  task automatic send_npc(input logic [31:0] a, input bit push);
    npc_valid = 1'b1;
    npc       = a;
    if (push) push_exp(a);
    tick();
    npc_valid = 1'b0;
    npc       = 32'h0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    check_eq({tag, "_ifu_valid"}, 64'(IFU_valid), 64'd0);
    check_eq({tag, "_ifu_ready"}, 64'(IFU_ready), 64'd0);
    check_eq({tag, "_pc"}, 64'(pc), 64'h8000_0000);
    check_eq({tag, "_inst"}, 64'(inst), 64'd0);
    check_eq({tag, "_fault"}, 64'(ifu_fault), 64'd0);
    check_eq({tag, "_fetch_cnt"}, fetch_cnt, 64'd0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; acc_cyc = 0; req_seen = 0;
    mem_mode = 0; exp_cnt = 64'd0;
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
    imem_rdata = 32'h0; imem_rsp_err = 1'b0; IDU_ready = 1'b0;
    npc_valid = 1'b0; npc = 32'h0;
    repeat (3) tick();
    check_reset("reset");

    // First fetch after release; request flop rises on the second edge.
    rst_n = 1'b1;
    rel_cyc = cyc;
    push_exp(32'h8000_0000);
    tick();
    check_eq("first_req_early", 64'(imem_req_valid), 64'd0);
    tick();
    check_eq("first_req", 64'(imem_req_valid), 64'd1);
    check_eq("first_addr", 64'(imem_addr), 64'h8000_0000);
    wait_valid("first");
    check_eq("first_latency", 64'(cyc - rel_cyc), 64'd4);

    repeat (5) begin
      tick();
      check_eq("stall_valid", 64'(IFU_valid), 64'd1);
      check_eq("stall_inst", 64'(inst), 64'h0000_0413);
      check_eq("stall_pc", 64'(pc), 64'h8000_0000);
    end
    handoff("stall");

    // Misaligned target: fault without touching the memory port.
    req_seen = 0;
    send_npc(32'h8000_0102, 1'b1);
    wait_valid("misalign");
    check_eq("misalign_no_req", 64'(req_seen), 64'd0);
    handoff("misalign");

    // Stray response in REQ and npc during VALID are both ignored.
    send_npc(32'h8000_0010, 1'b1);
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'hdead_beef;
    imem_rsp_err   = 1'b1;
    tick();
    wait_valid("stray");
    npc_valid = 1'b1;
    npc       = 32'h1234_5678;
    repeat (2) tick();
    npc_valid = 1'b0;
    check_eq("npc_in_valid_pc", 64'(pc), 64'h8000_0010);
    check_eq("npc_in_valid_state", 64'(IFU_valid), 64'd1);
    handoff("stray");

    mem_mode = 1;
    send_npc(32'h8000_0020, 1'b1);
    wait_valid("buserr");
    handoff("buserr");

    mem_mode = 2;
    send_npc(32'h8000_0030, 1'b1);
    wait_valid("timeout");
    check_eq("timeout_wait_cycles", 64'(cyc - acc_cyc), 64'd4);
    handoff("timeout");

    // Reset while a request is outstanding, then a late response.
    send_npc(32'h8000_0040, 1'b0);
    repeat (3) tick();
    check_eq("pre_reset_waiting", 64'(IFU_valid), 64'd0);
    rst_n = 1'b0;
    tick();
    check_reset("wait_reset");
    rst_n    = 1'b1;
    mem_mode = 0;
    exp_cnt  = 64'd0;
    rel_cyc  = cyc;
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'hbad0_bad0;
    push_exp(32'h8000_0000);
    tick();
    wait_valid("refetch");
    check_eq("refetch_latency", 64'(cyc - rel_cyc), 64'd4);
    check_eq("refetch_cnt0", fetch_cnt, 64'd0);
    handoff("refetch");

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
